fifo_rd_adapter: RTL and testbench
==================================

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have port rd_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port fifo_empty  input  1  empty flag of the upstream FIFO read side.
REQ-005 SHALL have port fifo_data  input  WIDTH  upstream FIFO registered read data, valid the cycle after a read is issued.
REQ-006 SHALL have port fifo_read  output  1  read strobe to the upstream FIFO.
REQ-007 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight data.
REQ-008 SHALL have port m_valid  output  1  downstream data valid.
REQ-009 SHALL have port m_ready  input  1  downstream accept.
REQ-010 SHALL have port m_data  output  WIDTH  downstream data, head of buffer.
REQ-011 SHALL have port word_count  output  16  delivered-word counter (present only with the macro, REQ-026).

Function
REQ-012 SHALL hold a 2-entry in-order buffer with occupancy occ (0..2) and an in-flight flag inflight (0/1).
REQ-013 SHALL drive fifo_read combinationally = !fifo_empty && !flush && (occ + inflight - pop) <= 1, where pop = m_valid && m_ready.
REQ-014 SHALL set inflight on the edge ending a cycle with fifo_read=1, and clear it otherwise.
REQ-015 SHALL, in a cycle with inflight=1, write fifo_data into the buffer tail at the end of that cycle (read-to-capture latency one cycle; read-to-m_valid latency two cycles).
REQ-016 SHALL drive m_valid = (occ != 0) and m_data = head entry; m_data stable while m_valid && !m_ready.
REQ-017 SHALL handle simultaneous capture and pop in one cycle: occ unchanged, order preserved.
REQ-018 SHALL never overflow: capture never occurs with occ=2 and no pop (guaranteed by REQ-013).
REQ-019 SHALL never assert fifo_read while fifo_empty=1.
REQ-020 SHALL sustain one word per cycle when fifo_empty=0 and m_ready=1 continuously.
REQ-021 SHALL, on flush=1, set occ=0 and inflight=0 at the next edge, drop any arriving in-flight word, and deassert fifo_read that cycle; a pop in the flush cycle still counts as delivered.
REQ-022 SHALL use wrap-around pointers (1 bit each) for buffer head and tail.

Reset
REQ-023 SHALL, while reset=0, asynchronously force occ=0, inflight=0, head=tail=0, m_valid=0, fifo_read=0, word_count=0.
REQ-024 SHALL ignore fifo_data contents (including X) whenever inflight=0, including after reset mid-transfer.
REQ-025 SHALL resume normal operation on the first rising edge after reset returns to 1.

Configuration
REQ-026 SHALL compile word_count only when macro FIFO_RD_ADAPTER_STATS_EN is defined: 16-bit counter, +1 per pop, wraps 0xFFFF->0x0000, not cleared by flush.
REQ-027 SHALL, without FIFO_RD_ADAPTER_STATS_EN, omit the word_count port and counter entirely; all other behaviour identical.

Structure
REQ-028 SHALL place buffer depth constant (2), occupancy width constant, and counter width (16) in shared package fifo_rd_adapter_pkg.
REQ-029 SHALL implement the 2-entry buffer as sub-module skid_buf2 (write, pop, data in/out, occ); read-credit logic, flush, and counter stay in fifo_rd_adapter.

Verification
REQ-030 SHALL verify streaming: FIFO preloaded 0x01..0x05, m_ready=1 -> fifo_read on 5 consecutive cycles, m_data 0x01..0x05 on 5 consecutive cycles starting 2 cycles after first read.
REQ-031 SHALL verify backpressure: m_ready=0 with FIFO non-empty -> exactly 2 reads issued, m_valid=1, m_data held at first word; m_ready=1 -> remaining words in order, no loss or duplicate.
REQ-032 SHALL verify empty: fifo_empty=1 throughout -> fifo_read never 1, m_valid stays 0.
REQ-033 SHALL verify flush: flush pulse with occ=2 and inflight=1 -> next cycle m_valid=0, in-flight word 0xAA never appears on m_data.
REQ-034 SHALL verify reset mid-operation: reset=0 with occ=2 -> m_valid, fifo_read fall immediately (before the next edge); after release, first delivered word is the next FIFO word.
REQ-035 SHALL verify counter (macro defined): 65537 pops -> word_count=0x0001; without the macro, design elaborates without word_count.

Source files
------------

// File: rtl/fifo_rd_adapter_pkg.sv
// Shared constants for the FIFO read adapter and its 2-entry buffer.
package fifo_rd_adapter_pkg;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CNT_W     = 16;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer with 1-bit wrap-around head/tail pointers.
module skid_buf2
  import fifo_rd_adapter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[tail_q] = wr_data;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      occ_d = occ_q + {{(OCC_W-1){1'b0}}, wr_en} - {{(OCC_W-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[head_q];
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a registered-read FIFO interface into a valid/ready stream.
// Define FIFO_RD_ADAPTER_STATS_EN to add the 16-bit word_count output.
module fifo_rd_adapter
  import fifo_rd_adapter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPTER_STATS_EN
  ,
  output logic [CNT_W-1:0] word_count
`endif
);

  localparam int unsigned CW = OCC_W + 1;

  logic             inflight_q, inflight_d;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic             wr_en;
  logic [CW-1:0]    committed;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign wr_en   = inflight_q && !flush;

  // Words held after this edge plus the one in flight; a read is safe
  // only if at most one slot is already spoken for.
  always_comb begin
    committed  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    fifo_read  = reset && !fifo_empty && !flush && (committed <= CW'(1));
    inflight_d = fifo_read;
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk    (rd_clk),
    .rst_n  (reset),
    .clr    (flush),
    .wr_en  (wr_en),
    .wr_data(fifo_data),
    .pop    (pop),
    .rd_data(m_data),
    .occ    (occ)
  );

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [CNT_W-1:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Self-checking bench for fifo_rd_adapter with an upstream FIFO model and
// a scoreboard of words read; checks word_count when FIFO_RD_ADAPTER_STATS_EN is set.
module tb_fifo_rd_adapter;

  logic       rd_clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'hEE;
  logic       fifo_read;
  logic       flush = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [15:0] word_count;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_adapter #(.WIDTH(8)) dut (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    .word_count(word_count)
`endif
  );

  typedef struct {
    logic       rd;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  logic       s_rd, s_valid, s_pop, s_flush;
  logic [7:0] s_data;
  int         pops = 0;
  logic [7:0] last_pop = 8'h00;
  logic [15:0] model_cnt = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check(name, word_count, model_cnt);
`endif
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) src.push_back(8'(first + i));
    fifo_empty = (src.size() == 0);
  endtask

  // Mid-cycle sampling plus scoreboard compare of delivered words.
  task automatic sample();
    @(negedge rd_clk);
    s_rd    = fifo_read;
    s_valid = m_valid;
    s_pop   = m_valid && m_ready;
    s_data  = m_data;
    s_flush = flush;
    check("no_read_when_empty", s_rd && fifo_empty, 0);
    if (s_pop) begin
      if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
      else check("pop_data", s_data, exp_q.pop_front());
      check("flushed_word_seen", s_data == 8'hAA, 0);
      pops++;
      last_pop  = s_data;
      model_cnt = model_cnt + 16'h1;
    end
  endtask

  // Upstream FIFO model: registered data valid after the read edge.
  task automatic advance();
    @(posedge rd_clk);
    #1;
    if (s_rd) begin
      fifo_data = src.pop_front();
      exp_q.push_back(fifo_data);
    end else begin
      fifo_data = 8'hEE;
    end
    if (s_flush) exp_q.delete();
    fifo_empty = (src.size() == 0);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    check(name, src.size() + exp_q.size(), 0);
  endtask

  vec_t tbl[8];
  int   reads;
  int   p0;
  bit   got;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 8'h01};
    tbl[3] = '{1'b1, 1'b1, 8'h02};
    tbl[4] = '{1'b1, 1'b1, 8'h03};
    tbl[5] = '{1'b0, 1'b1, 8'h04};
    tbl[6] = '{1'b0, 1'b1, 8'h05};
    tbl[7] = '{1'b0, 1'b0, 8'h00};

    // Reset with data already waiting upstream
    load(1, 5);
    repeat (2) begin
      sample();
      check("rst_fifo_read", s_rd, 0);
      check("rst_m_valid", s_valid, 0);
      advance();
    end
    chk_cnt("rst_word_count");
    reset   = 1'b1;
    m_ready = 1'b1;

    // Streaming, cycle-exact
    for (int t = 0; t < 8; t++) begin
      sample();
      check($sformatf("stream_read[%0d]", t), s_rd, tbl[t].rd);
      check($sformatf("stream_valid[%0d]", t), s_valid, tbl[t].valid);
      if (tbl[t].valid) check($sformatf("stream_data[%0d]", t), s_data, tbl[t].data);
      advance();
    end
    check("stream_pops", pops, 5);
    chk_cnt("stream_word_count");

    // Backpressure: only two reads may be issued
    m_ready = 1'b0;
    load(8'h10, 6);
    reads = 0;
    repeat (6) begin
      sample();
      reads += int'(s_rd);
      advance();
    end
    check("bp_reads", reads, 2);
    sample();
    check("bp_valid", s_valid, 1);
    check("bp_head", s_data, 8'h10);
    advance();
    m_ready = 1'b1;
    p0 = pops;
    drain("bp_drain", 60);
    check("bp_delivered", pops - p0, 6);
    check("bp_last", last_pop, 8'h15);

    // Empty upstream
    repeat (10) begin
      sample();
      check("empty_read", s_rd, 0);
      check("empty_valid", s_valid, 0);
      advance();
    end

    // Flush with one word buffered and 0xAA in flight
    m_ready = 1'b0;
    load(8'h21, 1);
    load(8'hAA, 1);
    tick();
    tick();
    flush = 1'b1;
    sample();
    check("flush1_pre_valid", s_valid, 1);
    check("flush1_read", s_rd, 0);
    advance();
    flush = 1'b0;
    sample();
    check("flush1_post_valid", s_valid, 0);
    advance();
    m_ready = 1'b1;
    load(8'h31, 2);
    p0 = pops;
    drain("flush1_drain", 40);
    check("flush1_delivered", pops - p0, 2);
    check("flush1_last", last_pop, 8'h32);

    // Flush with two buffered words and a pop in the flush cycle
    m_ready = 1'b0;
    load(8'h41, 3);
    repeat (3) tick();
    flush   = 1'b1;
    m_ready = 1'b1;
    p0 = pops;
    sample();
    check("flush2_pop", s_pop, 1);
    check("flush2_head", s_data, 8'h41);
    advance();
    flush = 1'b0;
    sample();
    check("flush2_post_valid", s_valid, 0);
    advance();
    drain("flush2_drain", 40);
    check("flush2_delivered", pops - p0, 2);
    check("flush2_last", last_pop, 8'h43);
    chk_cnt("flush_word_count");

    // Asynchronous reset with the buffer full
    m_ready = 1'b0;
    load(8'h51, 5);
    repeat (3) tick();
    check("mid_pre_valid", m_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_read", fifo_read, 0);
    exp_q.delete();
    model_cnt = 16'h0000;
    chk_cnt("mid_rst_word_count");
    repeat (2) tick();
    reset   = 1'b1;
    m_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      sample();
      if (s_pop) begin
        got = 1'b1;
        check("first_after_reset", s_data, 8'h53);
      end
      advance();
    end
    check("first_after_reset_seen", got, 1);
    drain("mid_drain", 40);
    check("mid_last", last_pop, 8'h55);

`ifdef FIFO_RD_ADAPTER_STATS_EN
    // Counter wrap: 65537 pops from reset
    reset = 1'b0;
    #1;
    exp_q.delete();
    model_cnt = 16'h0000;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 65537; i++) src.push_back({1'b0, 7'(i)});
    fifo_empty = 1'b0;
    p0 = pops;
    drain("cnt_drain", 66000);
    check("cnt_pops", pops - p0, 65537);
    check("cnt_wrap", word_count, 16'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
